// File: rtl/chain_gap_score_pkg.sv
// chain_gap_score_pkg: shared constants for the anchor-chaining datapath
package chain_gap_score_pkg;
  localparam int POS_W = 32;
  localparam int FRAC_W = 8;
  localparam logic [POS_W-1:0] NEG_INF = 32'h8000_0000;
  localparam int MAX_DIST_X_DEF = 5000;
  localparam int BW_DEF = 500;
endpackage

// File: rtl/chain_gap_score_ilog2.sv
// chain_gap_score_ilog2: floor(log2(x)), valid low when x is zero
module chain_gap_score_ilog2 import chain_gap_score_pkg::*; (
  input  logic [POS_W-1:0] x,
  output logic [4:0]       lg,
  output logic             valid
);
  // later iterations overwrite earlier ones, so the highest set bit wins
  always_comb begin
    lg = '0;
    for (int k = 0; k < POS_W; k++) if (x[k]) lg = 5'(k);
  end
  assign valid = |x;
endmodule

// File: rtl/chain_gap_score.sv
// chain_gap_score: three-stage pipelined chaining score of predecessor j for anchor i
module chain_gap_score import chain_gap_score_pkg::*; #(
  parameter int MAX_DIST_X = MAX_DIST_X_DEF,
  parameter int BW         = BW_DEF,
  parameter int TAG_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] ri,
  input  logic [POS_W-1:0] qi,
  input  logic [POS_W-1:0] rj,
  input  logic [POS_W-1:0] qj,
  input  logic [7:0]       q_span,
  input  logic [15:0]      avg_coef,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_score,
  output logic             out_reject,
  output logic [TAG_W-1:0] out_tag
);
  logic en, v1, v2;
  logic signed [POS_W:0] dr_c, dq_c, dr1, dq1, min_d;
  logic rej1_c, rej1, rej2_c, rej2, dr_lt, lg_v;
  logic [7:0] qs1;
  logic [15:0] ac1;
  logic [TAG_W-1:0] t1, t2;
  logic [POS_W-1:0] dd_c, sc_c, lin_c, sc2, lin2, score_c;
  logic [4:0] lg_c, lg_n, lg2;
  assign en = !out_valid | out_ready;
  assign in_ready = en;
  assign dr_c = $signed({1'b0, ri}) - $signed({1'b0, rj});
  assign dq_c = $signed({1'b0, qi}) - $signed({1'b0, qj});
  assign rej1_c = (dq_c <= 33'sd0) | (dr_c <= 33'sd0) |
                  (dq_c > 33'(MAX_DIST_X)) | (dr_c > 33'(MAX_DIST_X));
  // subtracting in the right order gives |dr-dq| truncated to 32 bits directly
  assign dr_lt = dr1 < dq1;
  assign dd_c = dr_lt ? dq1[POS_W-1:0] - dr1[POS_W-1:0] : dr1[POS_W-1:0] - dq1[POS_W-1:0];
  assign min_d = dr_lt ? dr1 : dq1;
  assign sc_c = (min_d < $signed({25'b0, qs1})) ? min_d[POS_W-1:0] : {24'b0, qs1};
  assign lin_c = ({16'b0, dd_c[15:0]} * {16'b0, ac1}) >> FRAC_W;
  assign rej2_c = rej1 | (dd_c > 32'(BW));
  assign lg_n = lg_v ? lg_c : '0;
  assign score_c = rej2 ? NEG_INF : sc2 - lin2 - 32'(lg2 >> 1);
  chain_gap_score_ilog2 u_ilog2 (.x(dd_c), .lg(lg_c), .valid(lg_v));
  // slot valids advance together; the visible result only changes when a valid slot lands
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_score <= '0;
      out_reject <= 1'b0;
      out_tag <= '0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      if (v2) begin
        out_score <= score_c;
        out_reject <= rej2;
        out_tag <= t2;
      end
    end
  // datapath registers; what bubble slots carry is don't-care
  always_ff @(posedge clk)
    if (en) begin
      dr1 <= dr_c;
      dq1 <= dq_c;
      rej1 <= rej1_c;
      qs1 <= q_span;
      ac1 <= avg_coef;
      t1 <= in_tag;
      sc2 <= sc_c;
      lin2 <= lin_c;
      lg2 <= lg_n;
      rej2 <= rej2_c;
      t2 <= t1;
    end
endmodule
